// File: rtl/drive_sequencer.sv
// drive_sequencer
//   Sits between the command receiver and the motor block. Accepts 8-bit drive
//   commands on a valid/ready handshake and produces registered instruction and
//   turn_angle outputs. A motor dead time (BRAKE) is inserted on every direction
//   reversal or mode change. A link-loss watchdog stops the car in DRIVE, and an
//   emergency stop forces a KICK that the motor state machine exits cleanly from.
//
// Ports
//   clk           system clock
//   rst           asynchronous active-high reset
//   cmd_valid     command byte valid
//   cmd_data      [4:0] instruction code, [7:5] turn angle
//   cmd_ready     combinational; high in IDLE/DRIVE/PATTERN while estop is low
//   estop         emergency stop level, already synchronous to clk
//   instruction   registered instruction code to the motor block
//   turn_angle    registered steering angle to the motor block
//   state_dbg     current state encoding
//   timeout_pulse one-cycle pulse on watchdog expiry
//   cmd_err       one-cycle pulse when an accepted command is invalid
//
// DEAD_CYCLES must be at least 2 so BRAKE has a KICK cycle and a zero cycle.
module drive_sequencer #(
    parameter int DEAD_CYCLES    = 10_000_000,
    parameter int TIMEOUT_CYCLES = 50_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    input  logic [7:0] cmd_data,
    output logic       cmd_ready,
    input  logic       estop,
    output logic [4:0] instruction,
    output logic [2:0] turn_angle,
    output logic [2:0] state_dbg,
    output logic       timeout_pulse,
    output logic       cmd_err
);

    localparam int CNT_MAX = (DEAD_CYCLES > TIMEOUT_CYCLES) ? DEAD_CYCLES : TIMEOUT_CYCLES;
    localparam int CW      = $clog2(CNT_MAX + 1);

    localparam logic [CW-1:0] DEAD_LAST = CW'(DEAD_CYCLES - 1);
    localparam logic [CW-1:0] TMO_LAST  = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [CW-1:0] CNT_SAT   = '1;

    localparam logic [4:0] KICK = 5'b01111;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_DRIVE   = 3'd1,
        S_PATTERN = 3'd2,
        S_BRAKE   = 3'd3,
        S_ESTOP   = 3'd4
    } state_t;

    state_t        r_state;
    state_t        r_target;
    logic [CW-1:0] r_cnt;
    logic [4:0]    r_instr;
    logic [2:0]    r_angle;
    logic [4:0]    r_pend_instr;
    logic [2:0]    r_pend_angle;
    logic          r_tmo;
    logic          r_err;

    // Command decode
    logic [4:0] w_code;
    logic [2:0] w_ang;
    logic       w_stop;
    logic       w_pat;
    logic       w_inv;
    logic       w_accept;
    logic       w_rev;
    logic       w_wd_exp;
    logic [2:0] w_cmd_ang;   // patterns always run with steering centred
    state_t     w_cmd_tgt;   // class of the command: where BRAKE should land

    assign w_code    = cmd_data[4:0];
    assign w_ang     = cmd_data[7:5];
    assign w_stop    = (w_code == 5'b00000);
    assign w_pat     = (w_code == 5'b11010) || (w_code == 5'b11001) || (w_code == 5'b10000);
    assign w_inv     = w_code[4] && !w_pat;
    assign w_cmd_ang = w_pat ? 3'd0 : w_ang;
    assign w_cmd_tgt = w_stop ? S_IDLE : (w_pat ? S_PATTERN : S_DRIVE);

    assign cmd_ready = ((r_state == S_IDLE) || (r_state == S_DRIVE) || (r_state == S_PATTERN)) && !estop;
    assign w_accept  = cmd_valid && cmd_ready;

    // Only a hard fwd<->rev flip needs a dead time; stopped or both-coil
    // directions can be changed on the fly.
    assign w_rev = ((r_instr[3:2] == 2'b10) && (w_code[3:2] == 2'b01)) ||
                   ((r_instr[3:2] == 2'b01) && (w_code[3:2] == 2'b10));

    assign w_wd_exp = (r_state == S_DRIVE) && (r_cnt == TMO_LAST);

    assign instruction   = r_instr;
    assign turn_angle    = r_angle;
    assign state_dbg     = r_state;
    assign timeout_pulse = r_tmo;
    assign cmd_err       = r_err;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_target     <= S_IDLE;
            r_cnt        <= '0;
            r_instr      <= 5'd0;
            r_angle      <= 3'd0;
            r_pend_instr <= 5'd0;
            r_pend_angle <= 3'd0;
            r_tmo        <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_tmo <= 1'b0;
            r_err <= 1'b0;
            if (estop) begin
                // Held KICK; anything pending is dropped, release goes via BRAKE to IDLE
                if (r_state != S_ESTOP) r_cnt <= '0;
                r_state      <= S_ESTOP;
                r_instr      <= KICK;
                r_angle      <= 3'd0;
                r_pend_instr <= 5'd0;
                r_pend_angle <= 3'd0;
                r_target     <= S_IDLE;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        r_cnt <= '0;
                        if (w_accept) begin
                            if (w_inv) begin
                                r_err <= 1'b1;
                            end else if (!w_stop) begin
                                r_state <= w_cmd_tgt;
                                r_instr <= w_code;
                                r_angle <= w_cmd_ang;
                            end
                        end
                    end

                    S_DRIVE: begin
                        if (w_wd_exp) begin
                            r_state      <= S_BRAKE;
                            r_target     <= S_IDLE;
                            r_pend_instr <= 5'd0;
                            r_pend_angle <= 3'd0;
                            r_instr      <= KICK;
                            r_angle      <= 3'd0;
                            r_cnt        <= '0;
                            r_tmo        <= 1'b1;
                        end else if (w_accept) begin
                            r_cnt <= '0;
                            if (w_inv) begin
                                r_err <= 1'b1;
                            end else if (w_stop) begin
                                r_state <= S_IDLE;
                                r_instr <= 5'd0;
                                r_angle <= 3'd0;
                            end else if (w_pat || w_rev) begin
                                r_state      <= S_BRAKE;
                                r_target     <= w_cmd_tgt;
                                r_pend_instr <= w_code;
                                r_pend_angle <= w_cmd_ang;
                                r_instr      <= KICK;
                                r_angle      <= 3'd0;
                            end else begin
                                r_instr <= w_code;
                                r_angle <= w_ang;
                            end
                        end else if (r_cnt != CNT_SAT) begin
                            r_cnt <= r_cnt + CW'(1);
                        end
                    end

                    S_PATTERN: begin
                        r_cnt <= '0;
                        if (w_accept) begin
                            if (w_inv) begin
                                r_err <= 1'b1;
                            end else if (!w_stop && (w_code != r_instr)) begin
                                r_state      <= S_BRAKE;
                                r_target     <= w_cmd_tgt;
                                r_pend_instr <= w_code;
                                r_pend_angle <= w_cmd_ang;
                                r_instr      <= KICK;
                                r_angle      <= 3'd0;
                            end
                        end
                    end

                    S_BRAKE: begin
                        if (r_cnt == DEAD_LAST) begin
                            r_state <= r_target;
                            r_instr <= r_pend_instr;
                            r_angle <= r_pend_angle;
                            r_cnt   <= '0;
                        end else begin
                            r_instr <= 5'd0;
                            r_angle <= 3'd0;
                            r_cnt   <= r_cnt + CW'(1);
                        end
                    end

                    S_ESTOP: begin
                        // estop has been released on this edge
                        r_state      <= S_BRAKE;
                        r_target     <= S_IDLE;
                        r_pend_instr <= 5'd0;
                        r_pend_angle <= 3'd0;
                        r_instr      <= KICK;
                        r_angle      <= 3'd0;
                        r_cnt        <= '0;
                    end

                    default: begin
                        r_state <= S_IDLE;
                        r_instr <= 5'd0;
                        r_angle <= 3'd0;
                        r_cnt   <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_drive_sequencer.sv
// Bench for drive_sequencer with short dead time / watchdog so every path
// is exercised in a few hundred cycles. Expected per-cycle outputs are queued
// as stimulus is driven and popped after each rising edge.
module tb_drive_sequencer;

    localparam int DEAD = 4;
    localparam int TMO  = 20;
    localparam logic [4:0] KICK = 5'b01111;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid;
    logic [7:0] cmd_data;
    logic       cmd_ready;
    logic       estop;
    logic [4:0] instruction;
    logic [2:0] turn_angle;
    logic [2:0] state_dbg;
    logic       timeout_pulse;
    logic       cmd_err;

    int checks = 0;
    int errors = 0;

    // {instruction, turn_angle, state_dbg, cmd_ready, cmd_err, timeout_pulse}
    logic [13:0] sbq[$];
    logic [13:0] e;
    logic [13:0] obs;

    always #5 clk = ~clk;

    drive_sequencer #(.DEAD_CYCLES(DEAD), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_data(cmd_data),
        .cmd_ready(cmd_ready), .estop(estop), .instruction(instruction),
        .turn_angle(turn_angle), .state_dbg(state_dbg),
        .timeout_pulse(timeout_pulse), .cmd_err(cmd_err)
    );

    function automatic logic [13:0] mk(input logic [4:0] ins, input logic [2:0] ang,
                                       input logic [2:0] st, input logic rdy,
                                       input logic err, input logic tmo);
        return {ins, ang, st, rdy, err, tmo};
    endfunction

    function automatic void push_brake(input logic tmo);
        sbq.push_back(mk(KICK, 3'd0, 3'd3, 1'b0, 1'b0, tmo));
        for (int i = 1; i < DEAD; i++) sbq.push_back(mk(5'd0, 3'd0, 3'd3, 1'b0, 1'b0, 1'b0));
    endfunction

    task automatic send(input logic [7:0] d);
        cmd_valid = 1'b1;
        cmd_data  = d;
    endtask

    task automatic test_reset();
        rst = 1'b1; estop = 1'b0; cmd_valid = 1'b0; cmd_data = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        obs = {instruction, turn_angle, state_dbg, cmd_ready, cmd_err, timeout_pulse};
        checks++;
        if (obs !== mk(5'd0, 3'd0, 3'd0, 1'b1, 1'b0, 1'b0)) begin
            errors++; $display("FAIL reset: got %h want %h", obs, mk(5'd0, 3'd0, 3'd0, 1'b1, 1'b0, 1'b0));
        end
        rst = 1'b0;
    endtask

    task automatic test_manual();
        send(8'h8A);
        sbq.push_back(mk(5'b01010, 3'd4, 3'd1, 1'b1, 1'b0, 1'b0));
        while (sbq.size() != 0) begin
            @(posedge clk); #1; cmd_valid = 1'b0;
            e = sbq.pop_front();
            obs = {instruction, turn_angle, state_dbg, cmd_ready, cmd_err, timeout_pulse};
            checks++;
            if (obs !== e) begin errors++; $display("FAIL manual: got %h want %h", obs, e); end
        end
    endtask

    task automatic test_reversal();
        send(8'h06);
        push_brake(1'b0);
        sbq.push_back(mk(5'b00110, 3'd0, 3'd1, 1'b1, 1'b0, 1'b0));
        while (sbq.size() != 0) begin
            @(posedge clk); #1; cmd_valid = 1'b0;
            e = sbq.pop_front();
            obs = {instruction, turn_angle, state_dbg, cmd_ready, cmd_err, timeout_pulse};
            checks++;
            if (obs !== e) begin errors++; $display("FAIL reversal: got %h want %h", obs, e); end
        end
        // same direction: immediate update, no dead time
        send(8'h65);
        sbq.push_back(mk(5'b00101, 3'd3, 3'd1, 1'b1, 1'b0, 1'b0));
        sbq.push_back(mk(5'b00101, 3'd3, 3'd1, 1'b1, 1'b0, 1'b0));
        while (sbq.size() != 0) begin
            @(posedge clk); #1; cmd_valid = 1'b0;
            e = sbq.pop_front();
            obs = {instruction, turn_angle, state_dbg, cmd_ready, cmd_err, timeout_pulse};
            checks++;
            if (obs !== e) begin errors++; $display("FAIL same_dir: got %h want %h", obs, e); end
        end
    endtask

    task automatic test_pattern();
        send(8'h19);
        push_brake(1'b0);
        sbq.push_back(mk(5'b11001, 3'd0, 3'd2, 1'b1, 1'b0, 1'b0));
        while (sbq.size() != 0) begin
            @(posedge clk); #1; cmd_valid = 1'b0;
            e = sbq.pop_front();
            obs = {instruction, turn_angle, state_dbg, cmd_ready, cmd_err, timeout_pulse};
            checks++;
            if (obs !== e) begin errors++; $display("FAIL pattern_enter: got %h want %h", obs, e); end
        end
        // stop is ignored and the watchdog does not run in PATTERN
        send(8'h00);
        for (int i = 0; i < TMO + 5; i++) sbq.push_back(mk(5'b11001, 3'd0, 3'd2, 1'b1, 1'b0, 1'b0));
        while (sbq.size() != 0) begin
            @(posedge clk); #1; cmd_valid = 1'b0;
            e = sbq.pop_front();
            obs = {instruction, turn_angle, state_dbg, cmd_ready, cmd_err, timeout_pulse};
            checks++;
            if (obs !== e) begin errors++; $display("FAIL pattern_hold: got %h want %h", obs, e); end
        end
        send(8'h1A);
        push_brake(1'b0);
        sbq.push_back(mk(5'b11010, 3'd0, 3'd2, 1'b1, 1'b0, 1'b0));
        while (sbq.size() != 0) begin
            @(posedge clk); #1; cmd_valid = 1'b0;
            e = sbq.pop_front();
            obs = {instruction, turn_angle, state_dbg, cmd_ready, cmd_err, timeout_pulse};
            checks++;
            if (obs !== e) begin errors++; $display("FAIL pattern_switch: got %h want %h", obs, e); end
        end
    endtask

    task automatic test_watchdog();
        // leave PATTERN for DRIVE via BRAKE
        send(8'h08);
        push_brake(1'b0);
        sbq.push_back(mk(5'b01000, 3'd0, 3'd1, 1'b1, 1'b0, 1'b0));
        while (sbq.size() != 0) begin
            @(posedge clk); #1; cmd_valid = 1'b0;
            e = sbq.pop_front();
            obs = {instruction, turn_angle, state_dbg, cmd_ready, cmd_err, timeout_pulse};
            checks++;
            if (obs !== e) begin errors++; $display("FAIL wd_enter: got %h want %h", obs, e); end
        end
        // last accept at edge k, expiry at edge k+TMO
        send(8'h08);
        for (int i = 0; i < TMO; i++) sbq.push_back(mk(5'b01000, 3'd0, 3'd1, 1'b1, 1'b0, 1'b0));
        push_brake(1'b1);
        sbq.push_back(mk(5'd0, 3'd0, 3'd0, 1'b1, 1'b0, 1'b0));
        while (sbq.size() != 0) begin
            @(posedge clk); #1; cmd_valid = 1'b0;
            e = sbq.pop_front();
            obs = {instruction, turn_angle, state_dbg, cmd_ready, cmd_err, timeout_pulse};
            checks++;
            if (obs !== e) begin errors++; $display("FAIL watchdog: got %h want %h", obs, e); end
        end
    endtask

    task automatic test_invalid();
        send(8'h1F);
        sbq.push_back(mk(5'd0, 3'd0, 3'd0, 1'b1, 1'b1, 1'b0));
        sbq.push_back(mk(5'd0, 3'd0, 3'd0, 1'b1, 1'b0, 1'b0));
        while (sbq.size() != 0) begin
            @(posedge clk); #1; cmd_valid = 1'b0;
            e = sbq.pop_front();
            obs = {instruction, turn_angle, state_dbg, cmd_ready, cmd_err, timeout_pulse};
            checks++;
            if (obs !== e) begin errors++; $display("FAIL invalid: got %h want %h", obs, e); end
        end
    endtask

    task automatic test_estop();
        send(8'h10);
        sbq.push_back(mk(5'b10000, 3'd0, 3'd2, 1'b1, 1'b0, 1'b0));
        while (sbq.size() != 0) begin
            @(posedge clk); #1; cmd_valid = 1'b0;
            e = sbq.pop_front();
            obs = {instruction, turn_angle, state_dbg, cmd_ready, cmd_err, timeout_pulse};
            checks++;
            if (obs !== e) begin errors++; $display("FAIL estop_pattern: got %h want %h", obs, e); end
        end
        send(8'h08);
        estop = 1'b1;
        #1;
        checks++;
        if (cmd_ready !== 1'b0) begin errors++; $display("FAIL estop_ready: got %b want 0", cmd_ready); end
        for (int i = 0; i < 3; i++) sbq.push_back(mk(KICK, 3'd0, 3'd4, 1'b0, 1'b0, 1'b0));
        while (sbq.size() != 0) begin
            @(posedge clk); #1; cmd_valid = 1'b0;
            e = sbq.pop_front();
            obs = {instruction, turn_angle, state_dbg, cmd_ready, cmd_err, timeout_pulse};
            checks++;
            if (obs !== e) begin errors++; $display("FAIL estop_hold: got %h want %h", obs, e); end
        end
        estop = 1'b0;
        sbq.push_back(mk(KICK, 3'd0, 3'd3, 1'b0, 1'b0, 1'b0));
        sbq.push_back(mk(5'd0, 3'd0, 3'd3, 1'b0, 1'b0, 1'b0));
        while (sbq.size() != 0) begin
            @(posedge clk); #1;
            e = sbq.pop_front();
            obs = {instruction, turn_angle, state_dbg, cmd_ready, cmd_err, timeout_pulse};
            checks++;
            if (obs !== e) begin errors++; $display("FAIL estop_release: got %h want %h", obs, e); end
        end
        // asynchronous reset mid-BRAKE, no clock edge in between
        rst = 1'b1;
        #1;
        obs = {instruction, turn_angle, state_dbg, cmd_ready, cmd_err, timeout_pulse};
        checks++;
        if (obs !== mk(5'd0, 3'd0, 3'd0, 1'b1, 1'b0, 1'b0)) begin
            errors++; $display("FAIL async_rst: got %h want %h", obs, mk(5'd0, 3'd0, 3'd0, 1'b1, 1'b0, 1'b0));
        end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < DEAD + 2; i++) sbq.push_back(mk(5'd0, 3'd0, 3'd0, 1'b1, 1'b0, 1'b0));
        while (sbq.size() != 0) begin
            @(posedge clk); #1;
            e = sbq.pop_front();
            obs = {instruction, turn_angle, state_dbg, cmd_ready, cmd_err, timeout_pulse};
            checks++;
            if (obs !== e) begin errors++; $display("FAIL rst_discard: got %h want %h", obs, e); end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] d [4];
        d = '{8'h28, 8'h49, 8'h6A, 8'h00};
        sbq.push_back(mk(5'b01000, 3'd1, 3'd1, 1'b1, 1'b0, 1'b0));
        sbq.push_back(mk(5'b01001, 3'd2, 3'd1, 1'b1, 1'b0, 1'b0));
        sbq.push_back(mk(5'b01010, 3'd3, 3'd1, 1'b1, 1'b0, 1'b0));
        sbq.push_back(mk(5'd0, 3'd0, 3'd0, 1'b1, 1'b0, 1'b0));
        for (int i = 0; i < 4; i++) begin
            send(d[i]);
            @(posedge clk); #1;
            e = sbq.pop_front();
            obs = {instruction, turn_angle, state_dbg, cmd_ready, cmd_err, timeout_pulse};
            checks++;
            if (obs !== e) begin errors++; $display("FAIL back_to_back[%0d]: got %h want %h", i, obs, e); end
        end
        cmd_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_manual();
        test_reversal();
        test_pattern();
        test_watchdog();
        test_invalid();
        test_estop();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
